psram_ctrl: RTL and testbench
=============================

# psram_ctrl

Parametrised asynchronous-mode controller for the board's 16-bit cellular PSRAM. It replaces fixed-timing, switch-driven RAM access with a valid/ready request port, per-byte write enables and configurable access timing. It sits between user logic, such as the synthesiser sample engine or a debug front-end, and the MemDB/MemAdr/Ram* board pins. Outputs to the memory are registered, and one request is outstanding at a time.

## Interface
Parameters:
- ADDR_W, 23, word-address width; must be ≤ 26; upper MemAdr bits are driven 0.
- RD_CYCLES, 7, clocks with MemOE low per read (≥ 70 ns at 100 MHz); must be ≥ 1.
- WR_CYCLES, 7, clocks with MemWR low per write; must be ≥ 1.
- TURN_CYCLES, 1, clocks of recovery with RamCS high after each access; must be ≥ 1.

Ports (all signals synchronous to clk except rst):
- clk  in  1  single system clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  16  write data.
- req_be  in  2  byte enables; bit0 = low byte, bit1 = high byte; used by writes only.
- rsp_valid  out  1  one-cycle completion pulse, for reads and writes.
- rsp_rdata  out  16  read data; holds its value until the next read completes.
- MemDB  inout  16  memory data bus.
- MemAdr  out  26  memory address, bits [26:1].
- RamCS, MemOE, MemWR, RamLB, RamUB  out  1 each  active-low memory strobes.
- RamAdv  out  1  held 0 (asynchronous mode).
- RamClk  out  1  held 0 (asynchronous mode).

## Operation
State machine: IDLE → SETUP → (RD_WAIT | WR_PULSE) → RECOVER → IDLE.

- **IDLE:**
  - req_ready = 1 and all strobes are inactive.
  - A handshake (req_valid & req_ready on a rising edge) latches req_we, req_addr, req_wdata and req_be, then moves to SETUP.
- **SETUP (1 cycle):**
  - MemAdr is driven with the latched address and RamCS goes 0.
  - For a write, MemDB is driven with the latched data.
  - RamLB/RamUB = ~be for a write and 0/0 for a read.
- **RD_WAIT (RD_CYCLES cycles):**
  - MemOE = 0.
  - On the last cycle's closing edge, MemDB is captured into rsp_rdata.
- **WR_PULSE (WR_CYCLES cycles):**
  - MemWR = 0, except that MemWR stays 1 when the latched be == 2'b00.
  - MemDB stays driven throughout.
- **RECOVER (TURN_CYCLES cycles):**
  - RamCS = 1, MemOE = 1 and MemWR = 1.
  - MemDB keeps being driven for the first RECOVER cycle of a write (data hold), then goes high-Z.
  - rsp_valid = 1 in the first RECOVER cycle only.
- **Down-counter:** a single counter, loaded on each state entry, times RD_WAIT, WR_PULSE and RECOVER.
- **Bus direction:** MemDB is high-Z in every state except the write data window.
- **Address and data stability:** MemAdr and the write data do not change from SETUP through the end of RECOVER.
- **Address mapping:** MemAdr = {zeros, addr}.
- **Ignored inputs:** changes to req_* while req_ready = 0 are ignored.

## Timing
- **Cycle numbering:** handshake edge = cycle 0.
- **Read:**
  - SETUP occupies cycle 1.
  - MemOE is low during cycles 2 … RD_CYCLES+1.
  - rsp_valid and the new rsp_rdata appear in cycle RD_CYCLES+2.
  - req_ready rises in cycle RD_CYCLES+2+TURN_CYCLES.
- **Write:**
  - MemWR is low during cycles 2 … WR_CYCLES+1.
  - rsp_valid appears in cycle WR_CYCLES+2.
  - req_ready rises in cycle WR_CYCLES+2+TURN_CYCLES.
- **Throughput:** back-to-back requests are possible with no idle gap beyond RECOVER; a request held valid in IDLE is accepted on the first edge.
- **Reset:**
  - Asserting rst (low) forces the following values immediately, mid-access included: state IDLE, RamCS = MemOE = MemWR = RamLB = RamUB = 1, RamAdv = RamClk = 0, MemAdr = 0, rsp_valid = 0, rsp_rdata = 0, MemDB high-Z.
  - req_ready = 0 while rst is low; it goes 1 on the first edge after release.
  - An aborted access produces no rsp_valid.
- **Output glitching:** all memory-side outputs come from flops, so there are no combinational glitches.

## Structure
- **psram_pkg:**
  - State enum (IDLE, SETUP, RD_WAIT, WR_PULSE, RECOVER).
  - Counter width localparam = $clog2 of max(RD_CYCLES, WR_CYCLES, TURN_CYCLES) + 1.
  - Inactive strobe constants.
- **psram_phy sub-module:** the output flops plus the MemDB tristate (data_out, data_oe, data_in). It keeps the tristate out of the FSM and makes the pin interface easy to swap for simulation models.

## Test plan
- **Reset then idle:** hold rst = 0 for 5 cycles, then release → all strobes 1, MemDB = Z, req_ready = 1 on the first edge after release, no rsp_valid.
- **Single write:** addr 0x000123, data 0xBEEF, be = 2'b11, defaults → MemWR low exactly cycles 2–8, MemAdr = 0x0000123, MemDB = 0xBEEF during cycles 1–9, rsp_valid in cycle 9, req_ready in cycle 10.
- **Read-back:** read 0x000123 against a PSRAM model → MemOE low cycles 2–8, rsp_rdata = 0xBEEF with rsp_valid in cycle 9.
- **Byte writes:** write 0x1234 with be = 2'b01, then 0xAB00 with be = 2'b10, then read → 0xAB34. A write with be = 2'b00 → MemWR never low, rsp_valid still at cycle 9, memory unchanged.
- **Parameter sweep:** RD_CYCLES = 1/3, WR_CYCLES = 2, TURN_CYCLES = 2 with back-to-back requests (valid held high) → latencies match the formulas and there is no overlap of RamCS between accesses.
- **Reset mid-access:** pull rst low during cycle 4 of a read → strobes go inactive within the same cycle, no rsp_valid, and the next request after release completes normally.

Source files
------------

// File: rtl/psram_ctrl_pkg.sv
// Shared constants and types for the asynchronous-mode PSRAM controller.
// Holds the FSM state codes, strobe bundle type and counter sizing helper.
package psram_ctrl_pkg;

    localparam int DATA_W    = 16;
    localparam int MEM_ADR_W = 26;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_WR_PULSE = 3'd3;
    localparam logic [2:0] ST_RECOVER  = 3'd4;

    // Active-low memory strobes, bundled so the PHY registers them as one word.
    typedef struct packed {
        logic cs_n;
        logic oe_n;
        logic wr_n;
        logic lb_n;
        logic ub_n;
    } strobe_t;

    localparam strobe_t STROBE_INACTIVE = 5'b11111;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/psram_ctrl_if.sv
// Request/response port of the PSRAM controller: valid/ready request plus
// a single-cycle completion pulse carrying read data.
interface psram_ctrl_if
    import psram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 23
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/psram_ctrl_phy.sv
// Pin-side output flops and MemDB tristate; every memory pin comes from a flop
// so the strobes cannot glitch.
module psram_ctrl_phy
    import psram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 23
)(
    input  logic                 clk,
    input  logic                 rst,
    input  strobe_t              i_strb,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [DATA_W-1:0]    i_dout,
    input  logic                 i_oe,
    output logic [DATA_W-1:0]    o_din,
    inout  wire  [DATA_W-1:0]    MemDB,
    output logic [MEM_ADR_W:1]   MemAdr,
    output logic                 RamCS,
    output logic                 MemOE,
    output logic                 MemWR,
    output logic                 RamLB,
    output logic                 RamUB,
    output logic                 RamAdv,
    output logic                 RamClk
);
    strobe_t                r_strb;
    logic [MEM_ADR_W-1:0]   r_adr;
    logic [DATA_W-1:0]      r_dout;
    logic                   r_oe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_strb <= STROBE_INACTIVE;
            r_adr  <= '0;
            r_dout <= '0;
            r_oe   <= 1'b0;
        end else begin
            r_strb <= i_strb;
            r_adr  <= MEM_ADR_W'(i_addr);
            r_dout <= i_dout;
            r_oe   <= i_oe;
        end
    end

    assign MemAdr = r_adr;
    assign RamCS  = r_strb.cs_n;
    assign MemOE  = r_strb.oe_n;
    assign MemWR  = r_strb.wr_n;
    assign RamLB  = r_strb.lb_n;
    assign RamUB  = r_strb.ub_n;
    assign RamAdv = 1'b0;
    assign RamClk = 1'b0;

    assign MemDB = r_oe ? r_dout : {DATA_W{1'bz}};
    assign o_din = MemDB;

endmodule

// File: rtl/psram_ctrl.sv
// Asynchronous-mode cellular PSRAM controller: one outstanding request,
// programmable read/write/recovery timing, per-byte write enables.
module psram_ctrl
    import psram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 23,
    parameter int RD_CYCLES   = 7,
    parameter int WR_CYCLES   = 7,
    parameter int TURN_CYCLES = 1
)(
    input  logic                clk,
    input  logic                rst,
    psram_ctrl_if.slave         bus,
    inout  wire  [DATA_W-1:0]   MemDB,
    output logic [MEM_ADR_W:1]  MemAdr,
    output logic                RamCS,
    output logic                MemOE,
    output logic                MemWR,
    output logic                RamLB,
    output logic                RamUB,
    output logic                RamAdv,
    output logic                RamClk
);
    localparam int CNT_W = cnt_width(RD_CYCLES, WR_CYCLES, TURN_CYCLES);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_be;
    logic              r_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic              w_hs;
    logic              w_last;
    logic [2:0]        w_state_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_we_next;
    logic [ADDR_W-1:0] w_addr_next;
    logic [DATA_W-1:0] w_wdata_next;
    logic [1:0]        w_be_next;
    logic              w_active_next;
    strobe_t           w_strb_next;
    logic              w_oe_next;
    logic [DATA_W-1:0] w_data_in;

    always_comb begin
        w_hs         = bus.req_valid & r_ready;
        w_last       = (r_cnt == CNT_W'(1));
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) w_state_next = ST_SETUP;
            end
            ST_SETUP: begin
                w_state_next = r_we ? ST_WR_PULSE : ST_RD_WAIT;
                w_cnt_next   = r_we ? CNT_W'(WR_CYCLES) : CNT_W'(RD_CYCLES);
            end
            ST_RD_WAIT, ST_WR_PULSE: begin
                if (w_last) begin
                    w_state_next = ST_RECOVER;
                    w_cnt_next   = CNT_W'(TURN_CYCLES);
                end else begin
                    w_cnt_next   = r_cnt - CNT_W'(1);
                end
            end
            ST_RECOVER: begin
                if (w_last) w_state_next = ST_IDLE;
                else        w_cnt_next   = r_cnt - CNT_W'(1);
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request fields are captured only on the handshake, so MemAdr and the
    // write data stay frozen for the whole access.
    always_comb begin
        w_we_next    = w_hs ? bus.req_we    : r_we;
        w_addr_next  = w_hs ? bus.req_addr  : r_addr;
        w_wdata_next = w_hs ? bus.req_wdata : r_wdata;
        w_be_next    = w_hs ? bus.req_be    : r_be;
    end

    // Pin values are derived from the next state so the PHY flops present
    // them exactly in the cycle the FSM occupies that state.
    always_comb begin
        w_active_next    = (w_state_next == ST_SETUP) || (w_state_next == ST_RD_WAIT) ||
                           (w_state_next == ST_WR_PULSE);
        w_strb_next      = STROBE_INACTIVE;
        w_strb_next.cs_n = ~w_active_next;
        w_strb_next.oe_n = ~(w_state_next == ST_RD_WAIT);
        w_strb_next.wr_n = ~((w_state_next == ST_WR_PULSE) && (w_be_next != 2'b00));
        if (w_active_next) begin
            w_strb_next.lb_n = w_we_next ? ~w_be_next[0] : 1'b0;
            w_strb_next.ub_n = w_we_next ? ~w_be_next[1] : 1'b0;
        end
        w_oe_next = w_we_next && ((w_state_next == ST_SETUP) || (w_state_next == ST_WR_PULSE) ||
                                  ((w_state_next == ST_RECOVER) && (r_state == ST_WR_PULSE)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= 2'b00;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_we        <= w_we_next;
            r_addr      <= w_addr_next;
            r_wdata     <= w_wdata_next;
            r_be        <= w_be_next;
            r_ready     <= (w_state_next == ST_IDLE);
            r_rsp_valid <= (w_state_next == ST_RECOVER) && (r_state != ST_RECOVER);
            if ((r_state == ST_RD_WAIT) && w_last)
                r_rsp_rdata <= w_data_in;
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;

    psram_ctrl_phy #(
        .ADDR_W (ADDR_W)
    ) u_phy (
        .clk    (clk),
        .rst    (rst),
        .i_strb (w_strb_next),
        .i_addr (w_addr_next),
        .i_dout (w_wdata_next),
        .i_oe   (w_oe_next),
        .o_din  (w_data_in),
        .MemDB  (MemDB),
        .MemAdr (MemAdr),
        .RamCS  (RamCS),
        .MemOE  (MemOE),
        .MemWR  (MemWR),
        .RamLB  (RamLB),
        .RamUB  (RamUB),
        .RamAdv (RamAdv),
        .RamClk (RamClk)
    );

endmodule

// File: tb/tb_psram_ctrl.sv
// Bench for psram_ctrl: three timing configurations share one PSRAM pin model;
// expectations come from cycle formulas and a byte-merging reference memory.
module tb_psram_ctrl;
    import psram_ctrl_pkg::*;

    localparam int ADDR_W = 23;
    localparam int N_DUT  = 3;

    function automatic int rd_of(input int s);
        case (s)
            0:       return 7;
            1:       return 1;
            default: return 3;
        endcase
    endfunction
    function automatic int wr_of(input int s);
        return (s == 0) ? 7 : 2;
    endfunction
    function automatic int turn_of(input int s);
        return (s == 0) ? 1 : 2;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    logic              tb_valid = 1'b0;
    logic              tb_we    = 1'b0;
    logic [ADDR_W-1:0] tb_addr  = '0;
    logic [15:0]       tb_wdata = '0;
    logic [1:0]        tb_be    = 2'b00;

    logic        o_ready  [N_DUT];
    logic        o_rvalid [N_DUT];
    logic [15:0] o_rdata  [N_DUT];
    logic [15:0] o_db     [N_DUT];
    logic [26:1] o_adr    [N_DUT];
    logic        o_cs  [N_DUT];
    logic        o_oe  [N_DUT];
    logic        o_wr  [N_DUT];
    logic        o_lb  [N_DUT];
    logic        o_ub  [N_DUT];
    logic        o_adv [N_DUT];
    logic        o_rclk[N_DUT];

    logic        mdl_drive;
    logic [15:0] mdl_data;
    logic [15:0] pin_mem [0:4095];

    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
        psram_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
        wire [15:0] db;

        assign bus.req_valid = tb_valid && (sel == gi);
        assign bus.req_we    = tb_we;
        assign bus.req_addr  = tb_addr;
        assign bus.req_wdata = tb_wdata;
        assign bus.req_be    = tb_be;
        assign db = ((sel == gi) && mdl_drive) ? mdl_data : 16'hzzzz;

        psram_ctrl #(
            .ADDR_W      (ADDR_W),
            .RD_CYCLES   (rd_of(gi)),
            .WR_CYCLES   (wr_of(gi)),
            .TURN_CYCLES (turn_of(gi))
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .bus    (bus.slave),
            .MemDB  (db),
            .MemAdr (o_adr[gi]),
            .RamCS  (o_cs[gi]),
            .MemOE  (o_oe[gi]),
            .MemWR  (o_wr[gi]),
            .RamLB  (o_lb[gi]),
            .RamUB  (o_ub[gi]),
            .RamAdv (o_adv[gi]),
            .RamClk (o_rclk[gi])
        );

        assign o_ready[gi]  = bus.req_ready;
        assign o_rvalid[gi] = bus.rsp_valid;
        assign o_rdata[gi]  = bus.rsp_rdata;
        assign o_db[gi]     = db;
    end

    // Asynchronous PSRAM pin model answering whichever controller is selected.
    assign mdl_drive = !o_cs[sel] && !o_oe[sel] && o_wr[sel];
    assign mdl_data  = pin_mem[o_adr[sel][12:1]];

    always @(posedge clk) begin
        if (!o_cs[sel] && !o_wr[sel]) begin
            if (!o_lb[sel]) pin_mem[o_adr[sel][12:1]][7:0]  <= o_db[sel][7:0];
            if (!o_ub[sel]) pin_mem[o_adr[sel][12:1]][15:8] <= o_db[sel][15:8];
        end
    end

    // Reference memory: what each word should hold after the requests issued so far.
    logic [15:0] ref_mem [int];

    function automatic logic [15:0] ref_rd(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
    endfunction

    task automatic ref_wr(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic [1:0] be);
        logic [15:0] v;
        v = ref_rd(a);
        if (be[0]) v[7:0]  = d[7:0];
        if (be[1]) v[15:8] = d[15:8];
        ref_mem[int'(a)] = v;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        int idx;
        idx = $urandom_range(0, 15);
        return {11'(idx * 97 + 1), 12'(12'h300 + idx)};
    endfunction

    // One request on the selected controller, checked cycle by cycle against
    // the latency formulas. Entered just after a falling edge.
    task automatic do_txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [15:0] wdata,
                          input logic [1:0] be, input bit b2b, input string tag);
        int x, t, kend, waitc;
        logic [15:0] exp_rd;
        logic [6:0]  got_v, exp_v;
        x      = we ? wr_of(sel) : rd_of(sel);
        t      = turn_of(sel);
        kend   = x + 2 + t;
        exp_rd = ref_rd(addr);
        tb_valid = 1'b1; tb_we = we; tb_addr = addr; tb_wdata = wdata; tb_be = be;
        waitc = 0;
        while (!o_ready[sel] && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        total++;
        if (!o_ready[sel]) begin
            bad++;
            $display("FAIL %s ready_timeout got=0 exp=1", tag);
            tb_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        tb_valid = b2b;
        tb_we    = 1'($urandom);
        tb_addr  = ADDR_W'($urandom);
        tb_wdata = 16'($urandom);
        tb_be    = 2'($urandom);
        if (we) ref_wr(addr, wdata, be);
        for (int k = 1; k <= kend; k++) begin
            @(negedge clk);
            exp_v[6] = !(k <= x + 1);
            exp_v[5] = !(!we && k >= 2 && k <= x + 1);
            exp_v[4] = !(we && be != 2'b00 && k >= 2 && k <= x + 1);
            exp_v[3] = (k <= x + 1) ? (we ? !be[0] : 1'b0) : 1'b1;
            exp_v[2] = (k <= x + 1) ? (we ? !be[1] : 1'b0) : 1'b1;
            exp_v[1] = (k == x + 2);
            exp_v[0] = (k == kend);
            got_v = {o_cs[sel], o_oe[sel], o_wr[sel], o_lb[sel], o_ub[sel], o_rvalid[sel], o_ready[sel]};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL %s strobes k=%0d cs,oe,wr,lb,ub,rv,rdy got=%b exp=%b", tag, k, got_v, exp_v);
            end
            if (k <= x + 1 + t) begin
                total++;
                if (o_adr[sel] !== 26'(addr)) begin
                    bad++;
                    $display("FAIL %s memadr k=%0d got=%h exp=%h", tag, k, o_adr[sel], 26'(addr));
                end
            end
            if (we && k <= x + 2) begin
                total++;
                if (o_db[sel] !== wdata) begin
                    bad++;
                    $display("FAIL %s memdb k=%0d got=%h exp=%h", tag, k, o_db[sel], wdata);
                end
            end
            if (!we && k >= x + 2) begin
                total++;
                if (o_rdata[sel] !== exp_rd) begin
                    bad++;
                    $display("FAIL %s rdata k=%0d got=%h exp=%h", tag, k, o_rdata[sel], exp_rd);
                end
            end
        end
        $display("txn %s dut=%0d we=%0b addr=%h wdata=%h be=%b rdata=%h", tag, sel, we, addr, wdata, be,
                 o_rdata[sel]);
    endtask

    task automatic check_idle_pins(input string tag, input logic exp_ready);
        for (int s = 0; s < N_DUT; s++) begin
            total++;
            if ({o_cs[s], o_oe[s], o_wr[s], o_lb[s], o_ub[s], o_adv[s], o_rclk[s], o_rvalid[s], o_ready[s]} !==
                {7'b1111100, 1'b0, exp_ready}) begin
                bad++;
                $display("FAIL %s pins dut=%0d cs,oe,wr,lb,ub,adv,clk,rv,rdy got=%b exp=%b", tag, s,
                         {o_cs[s], o_oe[s], o_wr[s], o_lb[s], o_ub[s], o_adv[s], o_rclk[s], o_rvalid[s], o_ready[s]},
                         {7'b1111100, 1'b0, exp_ready});
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_idle_pins("reset_hold", 1'b0);
        for (int s = 0; s < N_DUT; s++) begin
            total++;
            if (o_adr[s] !== 26'h0 || o_rdata[s] !== 16'h0) begin
                bad++;
                $display("FAIL reset_regs dut=%0d adr got=%h exp=0 rdata got=%h exp=0", s, o_adr[s], o_rdata[s]);
            end
        end
        rst = 1'b1;
        #1 check_idle_pins("reset_release", 1'b0);
        @(negedge clk);
        check_idle_pins("first_edge", 1'b1);
    endtask

    task automatic test_single_write();
        sel = 0;
        do_txn(1'b1, 23'h000123, 16'hBEEF, 2'b11, 1'b0, "single_write");
    endtask

    task automatic test_read_back();
        sel = 0;
        do_txn(1'b0, 23'h000123, 16'h0000, 2'b00, 1'b0, "read_back");
    endtask

    task automatic test_byte_writes();
        sel = 0;
        do_txn(1'b1, 23'h000200, 16'h1234, 2'b01, 1'b0, "byte_lo");
        do_txn(1'b1, 23'h000200, 16'hAB00, 2'b10, 1'b0, "byte_hi");
        do_txn(1'b0, 23'h000200, 16'h0000, 2'b00, 1'b0, "byte_read");
        total++;
        if (o_rdata[0] !== 16'hAB34) begin
            bad++;
            $display("FAIL byte_merge got=%h exp=%h", o_rdata[0], 16'hAB34);
        end
        do_txn(1'b1, 23'h000200, 16'($urandom), 2'b00, 1'b0, "byte_none");
        do_txn(1'b0, 23'h000200, 16'h0000, 2'b00, 1'b0, "byte_none_read");
    endtask

    task automatic test_random();
        sel = 0;
        for (int i = 0; i < 12; i++)
            do_txn(1'($urandom), rand_addr(), 16'($urandom), 2'($urandom), 1'b0, "random");
    endtask

    task automatic test_back_to_back();
        for (int s = 1; s < N_DUT; s++) begin
            sel = s;
            for (int i = 0; i < 10; i++)
                do_txn(1'($urandom), rand_addr(), 16'($urandom), 2'($urandom), (i != 9), "b2b");
        end
    endtask

    task automatic test_reset_mid_access();
        int rv_seen;
        sel = 0;
        tb_valid = 1'b1; tb_we = 1'b0; tb_addr = 23'h000123; tb_be = 2'b00;
        @(posedge clk);
        #1 tb_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1 check_idle_pins("mid_reset", 1'b0);
        total++;
        if (o_adr[0] !== 26'h0 || o_rdata[0] !== 16'h0) begin
            bad++;
            $display("FAIL mid_reset_regs adr got=%h exp=0 rdata got=%h exp=0", o_adr[0], o_rdata[0]);
        end
        rv_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_rvalid[0]) rv_seen++;
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (o_rvalid[0]) rv_seen++;
        end
        total++;
        if (rv_seen != 0) begin
            bad++;
            $display("FAIL mid_reset_rsp got=%0d pulses exp=0", rv_seen);
        end
        do_txn(1'b0, 23'h000123, 16'h0000, 2'b00, 1'b0, "after_reset_read");
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) pin_mem[i] = 16'h0000;
        test_reset();
        test_single_write();
        test_read_back();
        test_byte_writes();
        test_random();
        test_back_to_back();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
